// File: rtl/in_out_mem_arbiter_pkg.sv
// Shared types for the two-requester single-port memory arbiter.
// Defines the memory geometry, the request record and the arbiter FSM and owner encodings.
package in_out_mem_arbiter_pkg;

  localparam int unsigned MEM_DEPTH = 32;
  localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);
  localparam int unsigned DATA_W    = 7;

  typedef logic [ADDR_W-1:0] bSizeT;
  typedef logic [DATA_W-1:0] dSt;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } memArbStateT;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } reqIdT;

  typedef struct packed {
    bSizeT index;
    logic  write;
    dSt    wdata;
  } memReqSt;

  function automatic logic [1:0] id_onehot(input reqIdT id);
    return (id == REQ_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/in_out_mem_arbiter_if.sv
// Bundle of both requester channels plus the memory port of the arbiter.
// The slave modport is the arbiter side; master is the requester/memory side.
interface in_out_mem_arbiter_if;
  import in_out_mem_arbiter_pkg::*;

  logic  reqA_valid;
  logic  reqA_ready;
  bSizeT reqA_index;
  logic  reqA_write;
  dSt    reqA_wdata;
  logic  rspA_valid;
  logic  rspA_ready;
  dSt    rspA_rdata;

  logic  reqB_valid;
  logic  reqB_ready;
  bSizeT reqB_index;
  logic  reqB_write;
  dSt    reqB_wdata;
  logic  rspB_valid;
  logic  rspB_ready;
  dSt    rspB_rdata;

  logic  mem_en;
  logic  mem_we;
  bSizeT mem_addr;
  dSt    mem_wdata;
  dSt    mem_rdata;

  modport slave (
    input  reqA_valid, reqA_index, reqA_write, reqA_wdata, rspA_ready,
    input  reqB_valid, reqB_index, reqB_write, reqB_wdata, rspB_ready,
    output reqA_ready, rspA_valid, rspA_rdata,
    output reqB_ready, rspB_valid, rspB_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output reqA_valid, reqA_index, reqA_write, reqA_wdata, rspA_ready,
    output reqB_valid, reqB_index, reqB_write, reqB_wdata, rspB_ready,
    input  reqA_ready, rspA_valid, rspA_rdata,
    input  reqB_ready, rspB_valid, rspB_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/in_out_mem_arbiter_rr_arb.sv
// Two-input arbiter: round-robin when enabled, otherwise fixed priority to input 0.
// Grant is combinational from valid; the last-grant memory moves only on accept.
module in_out_rr_arb
  import in_out_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] grant
);

  reqIdT last_grant;

  always_comb begin
    grant = valid;
    // Ties go to whoever was not served last; without round-robin A always wins.
    if (valid == 2'b11) begin
      if (enable && (last_grant == REQ_A)) grant = id_onehot(REQ_B);
      else                                 grant = id_onehot(REQ_A);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= REQ_B;
    else if (accept) last_grant <= grant[1] ? REQ_B : REQ_A;
  end

endmodule

// File: rtl/in_out_mem_arbiter.sv
// Shares one single-port memory between requesters A and B, one access in flight,
// one-cycle read latency, response held until the owner accepts it.
module in_out_mem_arbiter
  import in_out_mem_arbiter_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  in_out_mem_arbiter_if.slave  bus
);

  memArbStateT state;
  reqIdT       owner;
  logic        write_q;
  logic [1:0]  req_valid;
  logic [1:0]  grant;
  logic [1:0]  req_ready;
  logic        accept;
  memReqSt     win_req;

  assign req_valid = {bus.reqB_valid, bus.reqA_valid};

  in_out_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (req_valid),
    .enable (RR_ENABLE),
    .accept (accept),
    .grant  (grant)
  );

  assign req_ready      = (state == IDLE) ? grant : 2'b00;
  assign accept         = |req_ready;
  assign bus.reqA_ready = req_ready[0];
  assign bus.reqB_ready = req_ready[1];

  always_comb begin
    win_req = '{index: bus.reqA_index, write: bus.reqA_write, wdata: bus.reqA_wdata};
    if (grant[1]) win_req = '{index: bus.reqB_index, write: bus.reqB_write, wdata: bus.reqB_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      owner          <= REQ_A;
      write_q        <= 1'b0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.rspA_valid <= 1'b0;
      bus.rspB_valid <= 1'b0;
      bus.rspA_rdata <= '0;
      bus.rspB_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // The memory strobe is launched on the accept edge so it is registered in ISSUE.
          if (accept) begin
            owner         <= grant[1] ? REQ_B : REQ_A;
            write_q       <= win_req.write;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= win_req.write;
            bus.mem_addr  <= win_req.index;
            bus.mem_wdata <= win_req.wdata;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_en    <= 1'b0;
          bus.mem_we    <= 1'b0;
          bus.mem_addr  <= '0;
          bus.mem_wdata <= '0;
          state         <= CAPTURE;
        end
        CAPTURE: begin
          if (owner == REQ_A) begin
            bus.rspA_valid <= 1'b1;
            bus.rspA_rdata <= write_q ? '0 : bus.mem_rdata;
          end else begin
            bus.rspB_valid <= 1'b1;
            bus.rspB_rdata <= write_q ? '0 : bus.mem_rdata;
          end
          state <= RESP;
        end
        RESP: begin
          if (((owner == REQ_A) && bus.rspA_ready) || ((owner == REQ_B) && bus.rspB_ready)) begin
            bus.rspA_valid <= 1'b0;
            bus.rspB_valid <= 1'b0;
            bus.rspA_rdata <= '0;
            bus.rspB_rdata <= '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_in_out_mem_arbiter.sv
// Bench for in_out_mem_arbiter: directed vector table, grant-order and corner sequences,
// then random traffic checked cycle by cycle against a transaction-level reference model.
module tb_in_out_mem_arbiter;
  import in_out_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_load = 1'b0;
  always #5 clk = ~clk;

  in_out_mem_arbiter_if bus();
  in_out_mem_arbiter_if bus_fp();

  in_out_mem_arbiter #(.RR_ENABLE(1'b1)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
  in_out_mem_arbiter #(.RR_ENABLE(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

  dSt mem     [MEM_DEPTH];
  dSt mem_fp  [MEM_DEPTH];
  dSt ref_mem [MEM_DEPTH];

  // Behavioural single-port memories; rdata is junk unless a read was strobed last cycle.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i]    <= ref_mem[i];
        mem_fp[i] <= ref_mem[i];
      end
    end else begin
      if (bus.mem_en && bus.mem_we)       mem[bus.mem_addr]       <= bus.mem_wdata;
      if (bus_fp.mem_en && bus_fp.mem_we) mem_fp[bus_fp.mem_addr] <= bus_fp.mem_wdata;
    end
    bus.mem_rdata    <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : dSt'($urandom);
    bus_fp.mem_rdata <= (bus_fp.mem_en && !bus_fp.mem_we) ? mem_fp[bus_fp.mem_addr] : dSt'($urandom);
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit who, input bit vld, input bit wr, input bSizeT idx, input dSt wd);
    if (!who) begin
      bus.reqA_valid = vld; bus.reqA_write = wr; bus.reqA_index = idx; bus.reqA_wdata = wd;
    end else begin
      bus.reqB_valid = vld; bus.reqB_write = wr; bus.reqB_index = idx; bus.reqB_wdata = wd;
    end
  endtask

  task automatic set_valid(input bit fp, input bit who, input bit v);
    if (fp) begin
      if (who) bus_fp.reqB_valid = v; else bus_fp.reqA_valid = v;
    end else begin
      if (who) bus.reqB_valid = v; else bus.reqA_valid = v;
    end
  endtask

  task automatic clear_inputs();
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    bus.rspA_ready = 1'b1; bus.rspB_ready = 1'b1;
    bus_fp.reqA_valid = 1'b0; bus_fp.reqA_write = 1'b0; bus_fp.reqA_index = '0; bus_fp.reqA_wdata = '0;
    bus_fp.reqB_valid = 1'b0; bus_fp.reqB_write = 1'b0; bus_fp.reqB_index = '0; bus_fp.reqB_wdata = '0;
    bus_fp.rspA_ready = 1'b1; bus_fp.rspB_ready = 1'b1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_reqA_ready"}, bus.reqA_ready, 0);
    chk({tag, "_reqB_ready"}, bus.reqB_ready, 0);
    chk({tag, "_rspA_valid"}, bus.rspA_valid, 0);
    chk({tag, "_rspB_valid"}, bus.rspB_valid, 0);
    chk({tag, "_rspA_rdata"}, bus.rspA_rdata, 0);
    chk({tag, "_rspB_rdata"}, bus.rspB_rdata, 0);
    chk({tag, "_mem_en"},     bus.mem_en, 0);
    chk({tag, "_mem_we"},     bus.mem_we, 0);
    chk({tag, "_mem_addr"},   bus.mem_addr, 0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata, 0);
  endtask

  typedef struct {
    bit    who;
    bit    write;
    bSizeT index;
    dSt    wdata;
    dSt    rdata;
  } vec_t;

  vec_t vecs [6];

  // One isolated transaction; entered and left just after a rising edge.
  task automatic run_vec(input vec_t v);
    set_req(v.who, 1, v.write, v.index, v.wdata);
    @(negedge clk);
    chk("vec_ready_owner", v.who ? bus.reqB_ready : bus.reqA_ready, 1);
    chk("vec_ready_other", v.who ? bus.reqA_ready : bus.reqB_ready, 0);
    @(posedge clk); #1;
    set_req(v.who, 0, 0, '0, '0);
    @(negedge clk);
    chk("vec_issue_en",    bus.mem_en, 1);
    chk("vec_issue_we",    bus.mem_we, v.write);
    chk("vec_issue_addr",  bus.mem_addr, v.index);
    chk("vec_issue_wdata", bus.mem_wdata, v.wdata);
    @(negedge clk);
    chk("vec_capture_en", bus.mem_en, 0);
    chk("vec_capture_we", bus.mem_we, 0);
    chk("vec_capture_rsp", bus.rspA_valid | bus.rspB_valid, 0);
    @(negedge clk);
    chk("vec_rsp_valid", v.who ? bus.rspB_valid : bus.rspA_valid, 1);
    chk("vec_rsp_rdata", v.who ? bus.rspB_rdata : bus.rspA_rdata, v.rdata);
    chk("vec_rsp_other", v.who ? bus.rspA_valid : bus.rspB_valid, 0);
    chk("vec_rsp_mem_en", bus.mem_en, 0);
    @(negedge clk);
    chk("vec_rsp_done", bus.rspA_valid | bus.rspB_valid, 0);
    @(posedge clk); #1;
  endtask

  // Both requesters hold valid for four grants each; records the grant order (1 = B).
  task automatic run_order(input bit fp, input logic [7:0] exp_seq, input string name);
    int unsigned na = 4, nb = 4, n = 0;
    logic [7:0] seq = '0;
    logic ra, rb, va, vb;
    set_valid(fp, 0, 1);
    set_valid(fp, 1, 1);
    for (int cyc = 0; cyc < 200 && n < 8; cyc++) begin
      @(negedge clk);
      ra = fp ? bus_fp.reqA_ready : bus.reqA_ready;
      rb = fp ? bus_fp.reqB_ready : bus.reqB_ready;
      va = fp ? bus_fp.reqA_valid : bus.reqA_valid;
      vb = fp ? bus_fp.reqB_valid : bus.reqB_valid;
      if (ra && va) begin seq[3'(n)] = 1'b0; n++; na--; end
      if (rb && vb) begin seq[3'(n)] = 1'b1; n++; nb--; end
      @(posedge clk); #1;
      set_valid(fp, 0, na != 0);
      set_valid(fp, 1, nb != 0);
    end
    chk({name, "_count"}, n, 8);
    chk({name, "_order"}, seq, exp_seq);
    set_valid(fp, 0, 0);
    set_valid(fp, 1, 0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Reference model state for the random phase.
  bit      m_busy, m_owner, m_last;
  int      m_age;
  memReqSt m_req;
  dSt      m_data;
  bit      pa_v, pb_v;
  memReqSt pa, pb;

  initial begin
    bit ea, eb, seen, rsp_acc;
    dSt hold;

    rst_n = 1'b1;
    clear_inputs();
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = dSt'(i);
    ref_mem[5] = 7'h2A;
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("reset");
    chk("reset_fp_mem_en", bus_fp.mem_en, 0);
    chk("reset_fp_rsp", bus_fp.rspA_valid | bus_fp.rspB_valid, 0);
    @(posedge clk); #1 mem_load = 1'b1;
    @(posedge clk); #1 mem_load = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{1'b0, 1'b0, 5'd5,  7'h11, 7'h2A};
    vecs[1] = '{1'b1, 1'b1, 5'd31, 7'h55, 7'h00};
    vecs[2] = '{1'b1, 1'b0, 5'd31, 7'h03, 7'h55};
    vecs[3] = '{1'b0, 1'b1, 5'd0,  7'h7F, 7'h00};
    vecs[4] = '{1'b0, 1'b0, 5'd0,  7'h00, 7'h7F};
    vecs[5] = '{1'b1, 1'b0, 5'd5,  7'h00, 7'h2A};
    foreach (vecs[i]) run_vec(vecs[i]);

    set_req(0, 0, 0, 5'd1, '0);
    set_req(1, 0, 0, 5'd2, '0);
    run_order(0, 8'hAA, "rr_order");
    run_order(1, 8'hF0, "fp_order");

    // Response backpressure on A while B waits.
    bus.rspA_ready = 1'b0;
    set_req(0, 1, 0, 5'd5, '0);
    @(negedge clk);
    chk("bp_acceptA", bus.reqA_ready, 1);
    @(posedge clk); #1;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 1, 0, 5'd7, '0);
    repeat (2) begin
      @(negedge clk);
      chk("bp_busy_reqB_ready", bus.reqB_ready, 0);
    end
    repeat (10) begin
      @(negedge clk);
      chk("bp_rspA_valid", bus.rspA_valid, 1);
      chk("bp_rspA_rdata", bus.rspA_rdata, 7'h2A);
      chk("bp_reqB_ready", bus.reqB_ready, 0);
      chk("bp_rspB_valid", bus.rspB_valid, 0);
    end
    @(posedge clk); #1 bus.rspA_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_reqB_ready", bus.reqB_ready, 0);
    chk("bp_hs_rspA_valid", bus.rspA_valid, 1);
    @(negedge clk);
    chk("bp_after_reqB_ready", bus.reqB_ready, 1);
    chk("bp_after_rspA_valid", bus.rspA_valid, 0);
    @(posedge clk); #1 set_req(1, 0, 0, '0, '0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.rspB_valid) begin
        seen = 1;
        chk("bp_rspB_rdata", bus.rspB_rdata, 7'h07);
      end
    end
    chk("bp_rspB_seen", seen, 1);
    repeat (3) @(posedge clk);
    #1;

    // Reset during CAPTURE of an A read: everything clears, no response, A wins next tie.
    set_req(0, 1, 0, 5'd5, '0);
    @(negedge clk);
    chk("mid_acceptA", bus.reqA_ready, 1);
    @(posedge clk); #1 set_req(0, 0, 0, '0, '0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk_quiet("mid_reset");
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mid_no_rsp", bus.rspA_valid | bus.rspB_valid, 0);
      chk("mid_no_mem_en", bus.mem_en, 0);
    end
    @(posedge clk); #1;
    set_req(0, 1, 0, 5'd1, '0);
    set_req(1, 1, 0, 5'd2, '0);
    @(negedge clk);
    chk("mid_tie_readyA", bus.reqA_ready, 1);
    chk("mid_tie_readyB", bus.reqB_ready, 0);
    @(posedge clk); #1;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (8) @(posedge clk);
    #1;

    // Random traffic against the transaction-level model.
    rst_n = 1'b0;
    clear_inputs();
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = dSt'($urandom);
    mem_load = 1'b1;
    @(posedge clk); #1 mem_load = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    m_busy = 0; m_last = 1; m_age = 0; m_owner = 0; m_data = '0; m_req = '0;
    pa_v = 0; pb_v = 0; pa = '0; pb = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!pa_v && $urandom_range(0, 2) != 0) begin
        pa_v = 1;
        pa.index = ($urandom_range(0, 4) == 0) ? 5'd31 : bSizeT'($urandom_range(0, 3));
        pa.write = 1'($urandom_range(0, 1));
        pa.wdata = dSt'($urandom);
      end
      if (!pb_v && $urandom_range(0, 2) != 0) begin
        pb_v = 1;
        pb.index = ($urandom_range(0, 4) == 0) ? 5'd31 : bSizeT'($urandom_range(0, 3));
        pb.write = 1'($urandom_range(0, 1));
        pb.wdata = dSt'($urandom);
      end
      set_req(0, pa_v, pa.write, pa.index, pa.wdata);
      set_req(1, pb_v, pb.write, pb.index, pb.wdata);
      bus.rspA_ready = 1'($urandom_range(0, 1));
      bus.rspB_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ea = 0; eb = 0;
      if (!m_busy) begin
        if (pa_v && pb_v) begin
          if (m_last) ea = 1; else eb = 1;
        end else begin
          ea = pa_v; eb = pb_v;
        end
      end
      chk("rnd_reqA_ready", bus.reqA_ready, ea);
      chk("rnd_reqB_ready", bus.reqB_ready, eb);
      chk("rnd_rspA_valid", bus.rspA_valid, m_busy && m_age >= 3 && !m_owner);
      chk("rnd_rspB_valid", bus.rspB_valid, m_busy && m_age >= 3 && m_owner);
      hold = (m_busy && m_age >= 3) ? m_data : '0;
      chk("rnd_rspA_rdata", bus.rspA_rdata, m_owner ? '0 : hold);
      chk("rnd_rspB_rdata", bus.rspB_rdata, m_owner ? hold : '0);
      chk("rnd_mem_en",    bus.mem_en, m_busy && m_age == 1);
      chk("rnd_mem_we",    bus.mem_we, m_busy && m_age == 1 && m_req.write);
      chk("rnd_mem_addr",  bus.mem_addr, (m_busy && m_age == 1) ? m_req.index : '0);
      chk("rnd_mem_wdata", bus.mem_wdata, (m_busy && m_age == 1) ? m_req.wdata : '0);
      rsp_acc = m_owner ? bus.rspB_ready : bus.rspA_ready;
      if (!m_busy) begin
        if (ea || eb) begin
          m_busy = 1; m_age = 1; m_owner = eb; m_last = eb;
          m_req = eb ? pb : pa;
          if (m_req.write) begin
            ref_mem[m_req.index] = m_req.wdata;
            m_data = '0;
          end else begin
            m_data = ref_mem[m_req.index];
          end
          if (eb) pb_v = 0; else pa_v = 0;
        end
      end else if (m_age >= 3 && rsp_acc) begin
        m_busy = 0;
      end else begin
        m_age++;
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/in_out_mem_arbiter.md
# in_out_mem_arbiter

Controller that shares one single-port 32-entry memory (addressed by bSizeT, data of type dSt) between two requesters, A and B. Each requester issues read or write requests over a ready/valid channel and receives one response per request on a separate ready/valid channel. The block arbitrates between the requesters, sequences the memory access with one-cycle read latency, and holds the response until the owning requester accepts it.

## Interface
- RR_ENABLE, 1: 1 selects round-robin arbitration; 0 selects fixed priority with A always winning.
- clk  in  1  Sole clock; all logic is rising-edge.
- rst_n  in  1  Asynchronous, active-low reset.
- reqA_valid / reqB_valid  in  1  Request present.
- reqA_ready / reqB_ready  out  1  Request accepted this cycle.
- reqA_index / reqB_index  in  5  Memory index, type bSizeT.
- reqA_write / reqB_write  in  1  1 = write, 0 = read.
- reqA_wdata / reqB_wdata  in  7  Write data, type dSt.
- rspA_valid / rspB_valid  out  1  Response present.
- rspA_ready / rspB_ready  in  1  Response accepted.
- rspA_rdata / rspB_rdata  out  7  Read data (dSt); 0 for writes.
- mem_en  out  1  Memory access strobe.
- mem_we  out  1  Write enable; qualified by mem_en.
- mem_addr  out  5  Memory index.
- mem_wdata  out  7  Memory write data.
- mem_rdata  in  7  Read data, valid the cycle after mem_en with mem_we=0.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP. Only one request is in flight at a time.
- IDLE:
  - reqX_ready=1 only for the arbitration winner, combinationally from the valid signals.
  - On acceptance, latch index, write and wdata plus the owner ID, then go to ISSUE.
  - The loser's ready stays 0 and its request must remain stable.
- ISSUE: drive registered mem_en=1, mem_we=write, mem_addr=index, mem_wdata=wdata for exactly one cycle, then go to CAPTURE.
- CAPTURE: register mem_rdata into the response data for a read, or 0 for a write, then go to RESP.
- RESP:
  - Assert rspX_valid for the owner only, with the data held stable.
  - On rspX_ready, return to IDLE.
  - The other rsp_valid stays 0.
- Arbitration:
  - last_grant resets to B, so A wins the first tie.
  - With RR_ENABLE=1 and both valid, the requester that was not last granted wins. A lone valid requester always wins.
  - last_grant updates only on acceptance.
- Outputs not listed for a state are 0. mem_addr and mem_wdata are 0 when mem_en=0.
- No address range check is needed: bSizeT covers all 32 entries, and index 31 wraps nowhere.
- Reset mid-operation: the FSM returns to IDLE and the in-flight request is dropped with no response. A write already strobed to memory stands.

## Timing
- Reset values: all ready, valid, mem_* and rdata outputs are 0; state is IDLE; last_grant is B.
- Request accepted at cycle T:
  - mem_en at T+1.
  - mem_rdata sampled at T+2.
  - rspX_valid from T+3.
- Response handshake at cycle R: IDLE at R+1, so the earliest next acceptance is R+1.
- Maximum throughput is one request per 4 cycles when rsp_ready is held high.
- No combinational path from rsp_ready to any output. req_ready depends combinationally only on req_valid and registered state.

## Structure
- Additions to the shared package:
  - memArbStateT enum (IDLE/ISSUE/CAPTURE/RESP).
  - reqIdT enum (REQ_A=0, REQ_B=1).
  - memReqSt {bSizeT index; logic write; dSt wdata}.
- Sub-module in_out_rr_arb: a 2-input arbiter holding last_grant, with inputs valid[1:0], enable and accept, and output grant one-hot. It is reusable for other shared resources.

## Test plan
- Single read: reset, then A reads index 5 with memory entry 5 = 7'h2A. Required: mem_en at T+1 with addr 5 and we=0; rspA_valid at T+3 with rdata 7'h2A; rspB_valid stays 0.
- Write then read: B writes 7'h55 to index 31, then reads index 31. Required: the write response has rdata 0; the read returns 7'h55; mem_we=1 only on the write ISSUE cycle.
- Round-robin: A and B both hold valid for 4 requests each. Required: grant order A,B,A,B,A,B,A,B. With RR_ENABLE=0, the order is A,A,A,A,B,B,B,B.
- Response backpressure: rspA_ready held 0 for 10 cycles while B is valid. Required: rspA_valid and rspA_rdata stay stable; reqB_ready stays 0 until the cycle after the rspA handshake.
- Reset mid-flight: assert rst_n=0 during CAPTURE. Required: all outputs go to 0 immediately; no response follows; the next tie after reset grants A.
